ssd1331_spi_sink: RTL and testbench

- Receive-side model of the OLED SPI link: deserializes SCLK/MOSI/CS/DC as driven by the display drawing path and decodes SSD1331 column/row window commands.
- Reassembles RGB565 pixel writes and emits each one with its panel (x,y) address.
- Used as an on-chip loopback checker and as the bench scoreboard front-end for the display path; samples the SPI pins with the system clock (SPI mode 0, MSB first).

---
 rtl/ssd1331_pkg.sv | 31 +++
 rtl/spi_sink_deser.sv | 114 +++++++++++
 rtl/ssd1331_spi_sink.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ssd1331_spi_sink.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1331_pkg.sv
// ssd1331_pkg: shared constants and types for the SSD1331 SPI receive-side sink.
//   - opcode constants for the column/row window commands
//   - decoder state enum
//   - default panel geometry
//   - argument clamp helpers used by the window decoder
package ssd1331_pkg;

   localparam int COLS_DEF = 96;
   localparam int ROWS_DEF = 64;

   localparam logic [7:0] CMD_SET_COL = 8'h15;
   localparam logic [7:0] CMD_SET_ROW = 8'h75;

   typedef enum logic [2:0] {
      ST_CMD,
      ST_COL_A,
      ST_COL_B,
      ST_ROW_A,
      ST_ROW_B
   } dec_state_e;

   // Compare in int so the check stays meaningful for any panel size.
   function automatic logic [6:0] clamp_col(input logic [6:0] v, input int max_v);
      return (int'(v) > max_v) ? 7'(max_v) : v;
   endfunction

   function automatic logic [5:0] clamp_row(input logic [5:0] v, input int max_v);
      return (int'(v) > max_v) ? 6'(max_v) : v;
   endfunction

endpackage

// File: rtl/spi_sink_deser.sv
// spi_sink_deser: samples SPI mode-0 pins with the system clock and rebuilds bytes.
//   clk, rst          system clock, asynchronous active-high reset
//   sclk, mosi, cs, dc raw SPI pins (cs active low)
//   byte_valid        one-cycle pulse, one clk after the 8th SCLK rise is seen
//   byte_data         last completed byte (MSB first)
//   byte_dc           dc sampled together with the 8th bit
//   err_frame         one-cycle pulse when cs rises with 1..7 bits held
module spi_sink_deser #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       cs,
   input  logic       dc,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc,
   output logic       err_frame
);

   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   // All four pins go through equal-depth chains so mosi/dc stay aligned
   // with the synchronized SCLK edge.
   logic [STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [STAGES-1:0] dc_sync_q,   dc_sync_d;
   logic              sclk_prev_q, sclk_prev_d;
   logic              cs_prev_q,   cs_prev_d;
   logic [6:0]        shift_q,     shift_d;
   logic [2:0]        bit_cnt_q,   bit_cnt_d;
   logic              byte_valid_q, byte_valid_d;
   logic [7:0]        byte_data_q, byte_data_d;
   logic              byte_dc_q,   byte_dc_d;
   logic              err_q,       err_d;

   logic sclk_s, mosi_s, cs_s, dc_s, sclk_rise, cs_rise;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sclk_sync_d  = {sclk_sync_q[STAGES-2:0], sclk};
      mosi_sync_d  = {mosi_sync_q[STAGES-2:0], mosi};
      cs_sync_d    = {cs_sync_q[STAGES-2:0], cs};
      dc_sync_d    = {dc_sync_q[STAGES-2:0], dc};
      sclk_s       = sclk_sync_q[STAGES-1];
      mosi_s       = mosi_sync_q[STAGES-1];
      cs_s         = cs_sync_q[STAGES-1];
      dc_s         = dc_sync_q[STAGES-1];
      sclk_rise    = sclk_s & ~sclk_prev_q;
      cs_rise      = cs_s & ~cs_prev_q;
      sclk_prev_d  = sclk_s;
      cs_prev_d    = cs_s;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      byte_dc_d    = byte_dc_q;
      err_d        = 1'b0;

      if (cs_s) begin
         // Deselected: drop any partial byte, flag it only on the rising cs edge.
         bit_cnt_d = '0;
         if (cs_rise && (bit_cnt_q != 3'd0)) err_d = 1'b1;
      end else if (sclk_rise) begin
         shift_d   = {shift_q[5:0], mosi_s};
         bit_cnt_d = bit_cnt_q + 3'd1;   // wraps 7 -> 0 at the byte boundary
         if (bit_cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = {shift_q, mosi_s};
            byte_dc_d    = dc_s;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q  <= '0;
         mosi_sync_q  <= '0;
         cs_sync_q    <= '1;          // cs idles high (deselected)
         dc_sync_q    <= '0;
         sclk_prev_q  <= 1'b0;
         cs_prev_q    <= 1'b1;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         byte_dc_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         cs_sync_q    <= cs_sync_d;
         dc_sync_q    <= dc_sync_d;
         sclk_prev_q  <= sclk_prev_d;
         cs_prev_q    <= cs_prev_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         byte_dc_q    <= byte_dc_d;
         err_q        <= err_d;
      end
   end

   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign byte_dc    = byte_dc_q;
   assign err_frame  = err_q;

endmodule

// File: rtl/ssd1331_spi_sink.sv
// ssd1331_spi_sink: receive-side model of the SSD1331 OLED SPI link.
//   Deserializes the SPI pins, decodes column (0x15) / row (0x75) window commands,
//   reassembles RGB565 pixels and emits each with its panel (x,y) address.
//   clk, rst                 system clock, asynchronous active-high reset
//   sclk, mosi, cs, dc       SPI pins (mode 0, MSB first, cs active low, dc=1 data)
//   byte_valid/data/dc       completed byte stream
//   cmd_valid, cmd_byte      any opcode other than the window commands
//   pixel_valid/x/y/color    completed pixel with its pre-increment address
//   win_col_*, win_row_*     current drawing window
//   err_frame                protocol error pulse
// Optional build macro SINK_STATS_EN adds saturating pixel_count (32b) and err_count (16b).
module ssd1331_spi_sink
   import ssd1331_pkg::*;
#(
   parameter int COLS        = COLS_DEF,
   parameter int ROWS        = ROWS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        cs,
   input  logic        dc,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_dc,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic        pixel_valid,
   output logic [6:0]  pixel_x,
   output logic [5:0]  pixel_y,
   output logic [15:0] pixel_color,
   output logic [6:0]  win_col_start,
   output logic [6:0]  win_col_end,
   output logic [5:0]  win_row_start,
   output logic [5:0]  win_row_end,
`ifdef SINK_STATS_EN
   output logic [31:0] pixel_count,
   output logic [15:0] err_count,
`endif
   output logic        err_frame
);

   localparam logic [6:0] COL_MAX = 7'(COLS - 1);
   localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);

   logic deser_err;

   spi_sink_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .mosi       (mosi),
      .cs         (cs),
      .dc         (dc),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_dc    (byte_dc),
      .err_frame  (deser_err)
   );

   dec_state_e  state_q, state_d;
   logic [6:0]  arg_q, arg_d;            // clamped start argument held until *_B
   logic [6:0]  col_start_q, col_start_d, col_end_q, col_end_d;
   logic [5:0]  row_start_q, row_start_d, row_end_q, row_end_d;
   logic [6:0]  x_q, x_d;
   logic [5:0]  y_q, y_d;
   logic [7:0]  hi_q, hi_d;
   logic        hi_pending_q, hi_pending_d;
   logic        pixel_valid_q, pixel_valid_d;
   logic [6:0]  pixel_x_q, pixel_x_d;
   logic [5:0]  pixel_y_q, pixel_y_d;
   logic [15:0] pixel_color_q, pixel_color_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_byte_q, cmd_byte_d;
   logic        err_frame_q, err_frame_d;

   logic        pix_byte, dec_err;
   logic [6:0]  col_end_v;
   logic [5:0]  row_end_v;

   always_comb begin
      state_d       = state_q;
      arg_d         = arg_q;
      col_start_d   = col_start_q;
      col_end_d     = col_end_q;
      row_start_d   = row_start_q;
      row_end_d     = row_end_q;
      x_d           = x_q;
      y_d           = y_q;
      hi_d          = hi_q;
      hi_pending_d  = hi_pending_q;
      pixel_valid_d = 1'b0;
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      pixel_color_d = pixel_color_q;
      cmd_valid_d   = 1'b0;
      cmd_byte_d    = cmd_byte_q;
      pix_byte      = 1'b0;
      dec_err       = 1'b0;
      col_end_v     = clamp_col(byte_data[6:0], COLS - 1);
      row_end_v     = clamp_row(byte_data[5:0], ROWS - 1);

      if (byte_valid) begin
         // A command byte between the two halves of a pixel orphans the high byte.
         if (!byte_dc && hi_pending_q) begin
            dec_err      = 1'b1;
            hi_pending_d = 1'b0;
         end

         unique case (state_q)
            ST_CMD: begin
               if (byte_dc)                        pix_byte = 1'b1;
               else if (byte_data == CMD_SET_COL)  state_d  = ST_COL_A;
               else if (byte_data == CMD_SET_ROW)  state_d  = ST_ROW_A;
               else begin
                  cmd_valid_d = 1'b1;
                  cmd_byte_d  = byte_data;
               end
            end
            ST_COL_A, ST_ROW_A: begin
               if (byte_dc) begin
                  dec_err  = 1'b1;
                  pix_byte = 1'b1;
                  state_d  = ST_CMD;
               end else if (state_q == ST_COL_A) begin
                  arg_d   = clamp_col(byte_data[6:0], COLS - 1);
                  state_d = ST_COL_B;
               end else begin
                  arg_d   = {1'b0, clamp_row(byte_data[5:0], ROWS - 1)};
                  state_d = ST_ROW_B;
               end
            end
            ST_COL_B: begin
               state_d = ST_CMD;
               if (byte_dc) begin
                  dec_err  = 1'b1;
                  pix_byte = 1'b1;
               end else begin
                  if (col_end_v < arg_q) col_end_v = arg_q;
                  col_start_d = arg_q;
                  col_end_d   = col_end_v;
                  x_d         = arg_q;
               end
            end
            ST_ROW_B: begin
               state_d = ST_CMD;
               if (byte_dc) begin
                  dec_err  = 1'b1;
                  pix_byte = 1'b1;
               end else begin
                  if (row_end_v < arg_q[5:0]) row_end_v = arg_q[5:0];
                  row_start_d = arg_q[5:0];
                  row_end_d   = row_end_v;
                  y_d         = arg_q[5:0];
               end
            end
            default: state_d = ST_CMD;
         endcase

         // Window writes and pixel bytes are mutually exclusive, so the pointer
         // increment below never competes with a window update.
         if (pix_byte) begin
            if (!hi_pending_q) begin
               hi_d         = byte_data;
               hi_pending_d = 1'b1;
            end else begin
               pixel_valid_d = 1'b1;
               pixel_x_d     = x_q;
               pixel_y_d     = y_q;
               pixel_color_d = {hi_q, byte_data};
               hi_pending_d  = 1'b0;
               if (x_q == col_end_q) begin
                  x_d = col_start_q;
                  y_d = (y_q == row_end_q) ? row_start_q : y_q + 6'd1;
               end else begin
                  x_d = x_q + 7'd1;
               end
            end
         end
      end

      err_frame_d = deser_err | dec_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_CMD;
         arg_q         <= '0;
         col_start_q   <= '0;
         col_end_q     <= COL_MAX;
         row_start_q   <= '0;
         row_end_q     <= ROW_MAX;
         x_q           <= '0;
         y_q           <= '0;
         hi_q          <= '0;
         hi_pending_q  <= 1'b0;
         pixel_valid_q <= 1'b0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         pixel_color_q <= '0;
         cmd_valid_q   <= 1'b0;
         cmd_byte_q    <= '0;
         err_frame_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         arg_q         <= arg_d;
         col_start_q   <= col_start_d;
         col_end_q     <= col_end_d;
         row_start_q   <= row_start_d;
         row_end_q     <= row_end_d;
         x_q           <= x_d;
         y_q           <= y_d;
         hi_q          <= hi_d;
         hi_pending_q  <= hi_pending_d;
         pixel_valid_q <= pixel_valid_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         pixel_color_q <= pixel_color_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_byte_q    <= cmd_byte_d;
         err_frame_q   <= err_frame_d;
      end
   end

`ifdef SINK_STATS_EN
   logic [31:0] pixel_count_q, pixel_count_d;
   logic [15:0] err_count_q,   err_count_d;

   always_comb begin
      pixel_count_d = pixel_count_q;
      err_count_d   = err_count_q;
      if (pixel_valid_q && (pixel_count_q != '1)) pixel_count_d = pixel_count_q + 32'd1;
      if (err_frame_q && (err_count_q != '1))     err_count_d   = err_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_count_q <= '0;
         err_count_q   <= '0;
      end else begin
         pixel_count_q <= pixel_count_d;
         err_count_q   <= err_count_d;
      end
   end

   assign pixel_count = pixel_count_q;
   assign err_count   = err_count_q;
`endif

   assign cmd_valid     = cmd_valid_q;
   assign cmd_byte      = cmd_byte_q;
   assign pixel_valid   = pixel_valid_q;
   assign pixel_x       = pixel_x_q;
   assign pixel_y       = pixel_y_q;
   assign pixel_color   = pixel_color_q;
   assign win_col_start = col_start_q;
   assign win_col_end   = col_end_q;
   assign win_row_start = row_start_q;
   assign win_row_end   = row_end_q;
   assign err_frame     = err_frame_q;

endmodule

// File: tb/tb_ssd1331_spi_sink.sv
// tb_ssd1331_spi_sink: directed bench for ssd1331_spi_sink (default build, no stats ports).
module tb_ssd1331_spi_sink;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        mosi = 1'b0;
   logic        cs = 1'b1;
   logic        dc = 1'b0;
   logic        byte_valid, byte_dc, cmd_valid, pixel_valid, err_frame;
   logic [7:0]  byte_data, cmd_byte;
   logic [6:0]  pixel_x, win_col_start, win_col_end;
   logic [5:0]  pixel_y, win_row_start, win_row_end;
   logic [15:0] pixel_color;

   ssd1331_spi_sink dut (
      .clk           (clk),
      .rst           (rst),
      .sclk          (sclk),
      .mosi          (mosi),
      .cs            (cs),
      .dc            (dc),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_dc       (byte_dc),
      .cmd_valid     (cmd_valid),
      .cmd_byte      (cmd_byte),
      .pixel_valid   (pixel_valid),
      .pixel_x       (pixel_x),
      .pixel_y       (pixel_y),
      .pixel_color   (pixel_color),
      .win_col_start (win_col_start),
      .win_col_end   (win_col_end),
      .win_row_start (win_row_start),
      .win_row_end   (win_row_end),
      .err_frame     (err_frame)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Event monitor, sampled on the falling edge away from DUT updates.
   typedef struct packed {
      logic [6:0]  x;
      logic [5:0]  y;
      logic [15:0] c;
   } pix_t;

   pix_t       px_q[$];
   int         bv_cnt = 0;
   int         cmd_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] last_cmd = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (byte_valid)  bv_cnt++;
         if (err_frame)   err_cnt++;
         if (cmd_valid) begin
            cmd_cnt++;
            last_cmd = cmd_byte;
         end
         if (pixel_valid) px_q.push_back('{x: pixel_x, y: pixel_y, c: pixel_color});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // Send n MSBs of b as one cs-framed transfer; SCLK period is 6 clk.
   task automatic send_bits(input logic [7:0] b, input logic d, input int n);
      @(negedge clk);
      cs = 1'b0;
      dc = d;
      repeat (3) @(negedge clk);
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         repeat (3) @(negedge clk);
         sclk = 1'b1;
         repeat (3) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (3) @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic d);
      send_bits(b, d, 8);
   endtask

   task automatic check_win(input string name, input logic [6:0] cs_e, input logic [6:0] ce_e,
                            input logic [5:0] rs_e, input logic [5:0] re_e);
      check({name, "_col_start"}, 32'(win_col_start), 32'(cs_e));
      check({name, "_col_end"},   32'(win_col_end),   32'(ce_e));
      check({name, "_row_start"}, 32'(win_row_start), 32'(rs_e));
      check({name, "_row_end"},   32'(win_row_end),   32'(re_e));
   endtask

   task automatic check_pix(input string name, input int idx, input logic [6:0] xe,
                            input logic [5:0] ye, input logic [15:0] ce);
      pix_t p;
      p = '0;
      if (idx < px_q.size()) p = px_q[idx];
      check({name, "_x"},     32'(p.x), 32'(xe));
      check({name, "_y"},     32'(p.y), 32'(ye));
      check({name, "_color"}, 32'(p.c), 32'(ce));
   endtask

   typedef struct {
      logic       dc;
      logic [7:0] data;
      int         cmd_inc;
      logic [6:0] cs_e;
      logic [6:0] ce_e;
      logic [5:0] rs_e;
      logic [5:0] re_e;
   } vec_t;

   vec_t vecs[7];
   int   c0, e0, b0;
   int   wrap_x[5];

   initial begin
      vecs[0] = '{1'b0, 8'hAE, 1, 7'd0, 7'd95, 6'd0, 6'd63};  // generic opcode
      vecs[1] = '{1'b0, 8'h15, 0, 7'd0, 7'd95, 6'd0, 6'd63};
      vecs[2] = '{1'b0, 8'h05, 0, 7'd0, 7'd95, 6'd0, 6'd63};  // start latched, window not yet
      vecs[3] = '{1'b0, 8'h05, 0, 7'd5, 7'd5,  6'd0, 6'd63};
      vecs[4] = '{1'b0, 8'h75, 0, 7'd5, 7'd5,  6'd0, 6'd63};
      vecs[5] = '{1'b0, 8'h00, 0, 7'd5, 7'd5,  6'd0, 6'd63};
      vecs[6] = '{1'b0, 8'h3F, 0, 7'd5, 7'd5,  6'd0, 6'd63};
      wrap_x  = '{0, 1, 0, 1, 0};

      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_byte_valid",  32'(byte_valid),  32'd0);
      check("rst_byte_data",   32'(byte_data),   32'd0);
      check("rst_cmd_valid",   32'(cmd_valid),   32'd0);
      check("rst_cmd_byte",    32'(cmd_byte),    32'd0);
      check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
      check("rst_pixel_xy",    32'({pixel_x, pixel_y}), 32'd0);
      check("rst_pixel_color", 32'(pixel_color), 32'd0);
      check("rst_err_frame",   32'(err_frame),   32'd0);
      check_win("rst", 7'd0, 7'd95, 6'd0, 6'd63);

      // Table: command bytes and window programming
      e0 = err_cnt;
      for (int i = 0; i < 7; i++) begin
         c0 = cmd_cnt;
         send_byte(vecs[i].data, vecs[i].dc);
         check($sformatf("vec%0d_cmd_inc", i), 32'(cmd_cnt - c0), 32'(vecs[i].cmd_inc));
         check_win($sformatf("vec%0d", i), vecs[i].cs_e, vecs[i].ce_e, vecs[i].rs_e, vecs[i].re_e);
      end
      check("vec_last_cmd", 32'(last_cmd), 32'h0000_00AE);
      check("vec_no_err", 32'(err_cnt - e0), 32'd0);

      // Column fill: single-column window walks y only
      px_q.delete();
      b0 = bv_cnt;
      for (int i = 0; i < 64; i++) begin
         send_byte(8'(i), 1'b1);
         send_byte(8'(8'hFF - i), 1'b1);
      end
      check("fill_bytes", 32'(bv_cnt - b0), 32'd128);
      check("fill_count", 32'(px_q.size()), 32'd64);
      for (int i = 0; i < 64; i++)
         check_pix($sformatf("fill%0d", i), i, 7'd5, 6'(i), {8'(i), 8'(8'hFF - i)});

      // Horizontal wrap in a 2x1 window
      send_byte(8'h15, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
      send_byte(8'h75, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h03, 1'b0);
      check_win("wrap", 7'd0, 7'd1, 6'd3, 6'd3);
      px_q.delete();
      for (int i = 0; i < 5; i++) begin
         send_byte(8'(8'hC0 + i), 1'b1);
         send_byte(8'h0F, 1'b1);
      end
      check("wrap_count", 32'(px_q.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         check_pix($sformatf("wrap%0d", i), i, 7'(wrap_x[i]), 6'd3, {8'(8'hC0 + i), 8'h0F});

      // Partial frame, then a generic command
      e0 = err_cnt;
      b0 = bv_cnt;
      send_bits(8'hA5, 1'b0, 3);
      check("partial_err", 32'(err_cnt - e0), 32'd1);
      check("partial_no_byte", 32'(bv_cnt - b0), 32'd0);
      c0 = cmd_cnt;
      send_byte(8'hAF, 1'b0);
      check("after_partial_cmd_inc", 32'(cmd_cnt - c0), 32'd1);
      check("after_partial_cmd_byte", 32'(last_cmd), 32'h0000_00AF);
      check_win("after_partial", 7'd0, 7'd1, 6'd3, 6'd3);

      // Argument clamp and end < start
      send_byte(8'h15, 1'b0); send_byte(8'h70, 1'b0); send_byte(8'h10, 1'b0);
      check_win("clamp", 7'd95, 7'd95, 6'd3, 6'd3);

      // Orphan high byte before a window command: command still decoded
      px_q.delete();
      e0 = err_cnt;
      c0 = cmd_cnt;
      send_byte(8'h12, 1'b1);
      send_byte(8'h15, 1'b0);
      check("orphan_err", 32'(err_cnt - e0), 32'd1);
      check("orphan_no_pixel", 32'(px_q.size()), 32'd0);
      send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0);
      check_win("orphan_col_a", 7'd16, 7'd32, 6'd3, 6'd3);
      check("orphan_no_cmd", 32'(cmd_cnt - c0), 32'd0);

      // Data byte where a column argument was expected
      e0 = err_cnt;
      send_byte(8'h15, 1'b0);
      send_byte(8'hAB, 1'b1);
      check("arg_dc_err", 32'(err_cnt - e0), 32'd1);
      check_win("arg_dc", 7'd16, 7'd32, 6'd3, 6'd3);
      send_byte(8'hCD, 1'b1);
      check("arg_dc_count", 32'(px_q.size()), 32'd1);
      check_pix("arg_dc_pix", 0, 7'd16, 6'd3, 16'hABCD);

      // Reset with a high byte pending
      send_byte(8'h99, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_win("rst_mid", 7'd0, 7'd95, 6'd0, 6'd63);
      px_q.delete();
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      check("rst_mid_count", 32'(px_q.size()), 32'd1);
      check_pix("rst_mid_pix", 0, 7'd0, 6'd0, 16'h1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
